riscv_core_vec_seq: RTL
=======================

RISCV_CORE_VEC_SEQ -- requirements
Module: riscv_core_vec_seq

Interface
REQ-001 SHALL have parameter WB_LAT, default 2: fixed read-to-writeback latency in unstalled cycles, legal range 1..4.
REQ-002 SHALL have parameter NELEM, default 64: elements per vector register.
REQ-003 SHALL have ports, one per line, clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_val  in  1  vector op offered.
- req_rdy  out  1  sequencer can accept an op.
- req_vs1, req_vs2, req_vd  in  5 each  source and destination vector registers.
- req_vl  in  7  vector length.
- req_rinter0, req_rinter1, req_winter  in  1 each  select the internal register (index 32).
- req_wen  in  1  op writes back.
- stall  in  1  downstream hold.
- v_raddr0, v_raddr1  out  5 each  read register addresses.
- v_ridx0, v_ridx1  out  6 each  first element of the read group.
- v_rinter0, v_rinter1  out  1 each  internal-register read select.
- rd_val  out  1  read group valid this cycle.
- v_wen_p  out  1  write enable.
- v_waddr_p  out  6  write register address; msb is always 0.
- v_widx_p  out  6  first element of the write group.
- v_lanes  out  2  active lanes minus 1.
- v_winter  out  1  internal-register write select.
- busy  out  1  op in flight.
- done  out  1  one-cycle completion pulse.

Function
REQ-004 SHALL implement states IDLE, ISSUE and DRAIN; req_rdy SHALL equal (state==IDLE).
REQ-005 SHALL, on req_val&&req_rdy, latch all req_* fields; vl SHALL be clamped to NELEM when req_vl>NELEM.
REQ-006 SHALL, on acceptance with a clamped vl of 0, issue no groups, stay in IDLE, and pulse done on the next cycle.
REQ-007 SHALL, on acceptance with vl>0, enter ISSUE with element counter elem=0.
REQ-008 SHALL, in ISSUE with stall==0, in the same cycle:
- assert rd_val;
- drive v_ridx0 = v_ridx1 = elem;
- set lanes = min(vl-elem, 4)-1;
- advance elem by 4.
REQ-009 SHALL leave ISSUE for DRAIN after issuing the group with elem+4>=vl.
REQ-010 SHALL hold elem, the state and all pipeline stages while stall==1; rd_val and v_wen_p SHALL be 0 while stall==1.
REQ-011 SHALL carry {valid, idx, lanes} of each issued group through WB_LAT stages, advancing only when stall==0.
REQ-012 SHALL assert v_wen_p when stage WB_LAT is valid, the latched wen==1 and stall==0, driving v_widx_p, v_lanes, v_waddr_p={1'b0,vd} and v_winter.
REQ-013 SHALL, in DRAIN, return to IDLE and pulse done in the cycle the last group leaves stage WB_LAT; this applies whether or not the op writes back.
REQ-014 SHALL keep v_ridx and v_widx below NELEM without wrap: groups never straddle element 63 because elem advances in steps of 4.
REQ-015 SHALL assert busy whenever state!=IDLE.
REQ-016 SHALL hold v_raddr0/1 and v_rinter0/1 at the latched values for the whole op.

Reset
REQ-017 SHALL, on reset_n==0 at any time, including mid-op, go to IDLE, clear elem and all pipeline valids, and drop any in-flight op.
REQ-018 SHALL hold these reset values: req_rdy=1; rd_val, v_wen_p, busy, done = 0; all address, index, lanes and inter outputs = 0.
REQ-019 SHALL produce no write in the cycle reset_n deasserts.

Structure
REQ-020 SHALL place the following in the shared vector package: NELEM, LANES=4, INTER_IDX=32, the state encoding, and the {valid, idx, lanes} group typedef.
REQ-021 SHALL implement the WB_LAT delay line as sub-module riscv_core_vec_wb_pipe (stall-aware shift register).

Verification
REQ-022 SHALL cover: vl=64, wen=1, no stall -> 16 reads at ridx 0,4,...,60; writes follow each read by 2 cycles with lanes=3; done pulses exactly once.
REQ-023 SHALL cover: vl=5 -> reads at idx 0 (lanes 3) and idx 4 (lanes 0); v_widx_p sequence 0, 4.
REQ-024 SHALL cover: vl=0 and vl=100 -> vl=0 gives no rd_val and done the next cycle; vl=100 behaves exactly as vl=64.
REQ-025 SHALL cover: stall asserted for 3 cycles mid-op -> no rd_val or v_wen_p during the stall, then the index sequence resumes unchanged with no duplicated or lost group.
REQ-026 SHALL cover: reset_n pulsed low during DRAIN -> all outputs at reset values immediately, and the next op accepted normally.
REQ-027 SHALL cover: req_winter=1, req_wen=0 -> v_wen_p never asserted, and done still pulses.

Source files
------------

// File: rtl/riscv_core_vec_seq_pkg.sv
// Shared vector-sequencer definitions: sizes, FSM encoding and the element-group
// record that travels down the writeback delay line.
package riscv_core_vec_seq_pkg;

   localparam int NELEM     = 64;
   localparam int LANES     = 4;
   localparam int INTER_IDX = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [5:0] idx;
      logic [1:0] lanes;
   } grp_t;

endpackage

// File: rtl/riscv_core_vec_wb_pipe.sv
// Stall-aware WB_LAT-deep delay line for issued element groups; also reports
// whether any group is still upstream of the final stage.
module riscv_core_vec_wb_pipe
   import riscv_core_vec_seq_pkg::*;
#(
   parameter int WB_LAT = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic stall,
   input  grp_t grp_in,
   output grp_t grp_out,
   output logic busy_up
);

   for (genvar g = 0; g < WB_LAT; g++) begin : g_stage
      grp_t d;
      grp_t q;
      logic any_up;

      if (g == 0) begin : g_head
         assign d      = grp_in;
         assign any_up = 1'b0;
      end else begin : g_tail
         assign d      = g_stage[g-1].q;
         assign any_up = g_stage[g-1].any_up | g_stage[g-1].q.valid;
      end

      // NOTE: these stages are flops rather than RAM, so they take the async
      // reset; a stale valid bit here would fire a write after reset.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            q <= '0;
         end else if (!stall) begin
            q <= d;
         end
      end
   end

   assign grp_out = g_stage[WB_LAT-1].q;
   assign busy_up = g_stage[WB_LAT-1].any_up;

endmodule

// File: rtl/riscv_core_vec_seq.sv
// Vector op sequencer: walks an op's elements in groups of four, issues register
// reads and replays each group as a write WB_LAT unstalled cycles later.
module riscv_core_vec_seq #(
   parameter int WB_LAT = 2,
   parameter int NELEM  = riscv_core_vec_seq_pkg::NELEM
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_val,
   output logic       req_rdy,
   input  logic [4:0] req_vs1,
   input  logic [4:0] req_vs2,
   input  logic [4:0] req_vd,
   input  logic [6:0] req_vl,
   input  logic       req_rinter0,
   input  logic       req_rinter1,
   input  logic       req_winter,
   input  logic       req_wen,
   input  logic       stall,
   output logic [4:0] v_raddr0,
   output logic [4:0] v_raddr1,
   output logic [5:0] v_ridx0,
   output logic [5:0] v_ridx1,
   output logic       v_rinter0,
   output logic       v_rinter1,
   output logic       rd_val,
   output logic       v_wen_p,
   output logic [5:0] v_waddr_p,
   output logic [5:0] v_widx_p,
   output logic [1:0] v_lanes,
   output logic       v_winter,
   output logic       busy,
   output logic       done
);
   import riscv_core_vec_seq_pkg::*;

   localparam logic [6:0] NELEM_W = 7'(NELEM);
   localparam logic [6:0] STEP    = 7'(LANES);

   state_t     state, state_nxt;
   logic [6:0] elem, vl_q, vl_clamp, rem;
   logic [4:0] vs1_q, vs2_q, vd_q;
   logic       rinter0_q, rinter1_q, winter_q, wen_q, zero_done_q;
   logic       accept, issue, last_out, wb_busy_up;
   logic [1:0] lanes;
   grp_t       grp_in, wb_grp;

   assign req_rdy  = (state == IDLE);
   assign accept   = req_val && req_rdy;
   assign vl_clamp = (req_vl > NELEM_W) ? NELEM_W : req_vl;
   assign rem      = vl_q - elem;
   assign lanes    = (rem >= STEP) ? 2'd3 : 2'(rem - 7'd1);

   // NOTE: every output of this block gets a default first so no path leaves
   // a signal unassigned and infers a latch.
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      last_out  = 1'b0;
      case (state)
         IDLE:  if (accept && vl_clamp != 7'd0) state_nxt = ISSUE;
         ISSUE: if (!stall) begin
            issue = 1'b1;
            if (elem + STEP >= vl_q) state_nxt = DRAIN;
         end
         DRAIN: if (wb_grp.valid && !stall && !wb_busy_up) begin
            last_out  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      grp_in = '0;
      if (issue) begin
         grp_in.valid = 1'b1;
         grp_in.idx   = elem[5:0];
         grp_in.lanes = lanes;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         elem        <= '0;
         vl_q        <= '0;
         vs1_q       <= '0;
         vs2_q       <= '0;
         vd_q        <= '0;
         rinter0_q   <= 1'b0;
         rinter1_q   <= 1'b0;
         winter_q    <= 1'b0;
         wen_q       <= 1'b0;
         zero_done_q <= 1'b0;
      end else begin
         zero_done_q <= accept && (vl_clamp == 7'd0);
         if (accept) begin
            elem      <= '0;
            vl_q      <= vl_clamp;
            vs1_q     <= req_vs1;
            vs2_q     <= req_vs2;
            vd_q      <= req_vd;
            rinter0_q <= req_rinter0;
            rinter1_q <= req_rinter1;
            winter_q  <= req_winter;
            wen_q     <= req_wen;
         end else if (issue) begin
            elem <= elem + STEP;
         end
      end
   end

   riscv_core_vec_wb_pipe #(.WB_LAT(WB_LAT)) u_wb_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .stall   (stall),
      .grp_in  (grp_in),
      .grp_out (wb_grp),
      .busy_up (wb_busy_up)
   );

   assign rd_val    = issue;
   assign v_raddr0  = vs1_q;
   assign v_raddr1  = vs2_q;
   assign v_rinter0 = rinter0_q;
   assign v_rinter1 = rinter1_q;
   assign v_ridx0   = elem[5:0];
   assign v_ridx1   = elem[5:0];
   assign v_wen_p   = wb_grp.valid && wen_q && !stall;
   assign v_waddr_p = {1'b0, vd_q};
   assign v_widx_p  = wb_grp.idx;
   assign v_lanes   = wb_grp.lanes;
   assign v_winter  = winter_q;
   assign busy      = (state != IDLE);
   assign done      = zero_done_q | last_out;

endmodule
